// File: rtl/fetch_queue.sv
// Instruction fetch queue: word fetches into a DEPTH-entry {insn, pc} buffer; first inst_valid 2 cycles after first grant.
// Backpressure: imem_req withheld while count+inflight reaches DEPTH; define FETCH_MISALIGN_CHK_EN for the misaligned-redirect fault.

module fetch_queue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_dat,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_dat,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW:0]      r_count;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign w_full  = (r_count == (PW+1)'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  // A pop in the same cycle frees the slot, so push is legal even when full.
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_dat   = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_dat;
  end
endmodule

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fq_entry_t;

  logic [31:0] r_pc;
  logic [31:0] r_inflight_pc;
  logic        r_inflight;
  logic        r_discard;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_occupancy;
  logic        w_accept;
  logic        w_enq;
  logic        w_deq;
  logic [31:0] w_redirect_target;
  fq_entry_t   w_enq_entry;
  fq_entry_t   w_head_entry;

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_fault;
  logic w_redirect_bad;

  assign w_redirect_bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_redirect_target = redirect_pc;
  assign fetch_fault       = r_fault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_fault <= 1'b0;
    else if (w_redirect_bad) r_fault <= 1'b1;
  end
`else
  assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_fault       = 1'b0;
`endif

  // Reserve a slot for the outstanding response so it can always be enqueued.
  assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign imem_req    = !reset && !redirect_valid && !fetch_fault &&
                       (w_occupancy < (CW+1)'(DEPTH));
  assign imem_addr   = r_pc;
  assign w_accept    = imem_req && imem_gnt;

  assign w_enq = imem_rvalid && r_inflight && !r_discard && !redirect_valid && !fetch_fault;
  assign w_deq = inst_valid && inst_ready;

  assign w_enq_entry.pc   = r_inflight_pc;
  assign w_enq_entry.insn = imem_rdata;

  assign inst_valid = (w_count != '0);
  assign inst_data  = w_head_entry.insn;
  assign inst_pc    = w_head_entry.pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_discard     <= 1'b0;
    end else begin
      if (redirect_valid) r_pc <= w_redirect_target;
      else if (w_accept)  r_pc <= r_pc + 32'd4;

      if (w_accept) begin
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_pc;
        r_discard     <= 1'b0;
      end else if (imem_rvalid) begin
        r_inflight <= 1'b0;
        r_discard  <= 1'b0;
      end else if (redirect_valid && r_inflight) begin
        r_discard <= 1'b1;
      end
    end
  end

  fetch_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fq_entry_t))
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .i_flush (redirect_valid),
    .i_push  (w_enq),
    .i_dat   (w_enq_entry),
    .i_pop   (w_deq),
    .o_dat   (w_head_entry),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: bench-side memory plus a queue-based reference of the expected instruction stream.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  // Reference: PCs of words delivered but not consumed, plus next fetch address.
  logic [31:0] m_q[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_pend_pc;
  int          m_pend;
  bit          m_fault;
  int          n_cyc = 0;
  int          first_acc = -1;
  int          first_valid = -1;
  bit          obs_valid;
  logic [31:0] obs_pc;

  task automatic model_reset();
    m_q.delete();
    m_pend     = 0;
    m_fault    = 1'b0;
    m_fetch_pc = RESET_PC;
  endtask

  task automatic cycle(input logic gnt, input logic rdy, input logic redir, input logic [31:0] tgt);
    logic        m_req, m_acc, m_deq, m_enq, dut_acc, bad_tgt;
    logic [31:0] acc_addr;
    imem_gnt       = gnt;
    inst_ready     = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    @(negedge clk);
    m_req = !redir && !m_fault && (m_q.size() + m_pend < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) chk("imem_addr", imem_addr, m_fetch_pc);
    chk("inst_valid", 32'(inst_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("inst_pc", inst_pc, m_q[0]);
      chk("inst_data", inst_data, mem_word(m_q[0]));
    end
    chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    obs_valid = inst_valid;
    obs_pc    = inst_pc;
    dut_acc   = imem_req && imem_gnt;
    acc_addr  = imem_addr;
    if (dut_acc && first_acc < 0) first_acc = n_cyc;
    if (inst_valid && first_valid < 0) first_valid = n_cyc;
    m_acc = m_req && gnt;
    m_deq = (m_q.size() != 0) && rdy;
    m_enq = (m_pend != 0) && !redir && !m_fault;
    @(posedge clk);
    #1;
    n_cyc++;
    bad_tgt = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    bad_tgt = (tgt[1:0] != 2'b00);
`endif
    if (redir) begin
      m_q.delete();
      m_pend = 0;
      if (bad_tgt) m_fault = 1'b1;
      m_fetch_pc = tgt & 32'hFFFF_FFFC;
    end else begin
      if (m_deq) void'(m_q.pop_front());
      if (m_enq) m_q.push_back(m_pend_pc);
      if (m_acc) begin
        m_pend     = 1;
        m_pend_pc  = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 32'd4;
      end else begin
        m_pend = 0;
      end
    end
    imem_rvalid = dut_acc;
    imem_rdata  = dut_acc ? mem_word(acc_addr) : 32'($urandom);
  endtask

  // Entered just after a rising edge; reset pulses between edges.
  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    #1 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    bit found;
    reset          = 1'b1;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("first_valid_latency", 32'(first_valid - first_acc), 32'd2);

    repeat (DEPTH + 4) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (obs_valid) found = 1'b1;
    end
    chk("redir_seen", 32'(found), 32'd1);
    if (found) chk("redir_first_pc", obs_pc, 32'h0000_0100);

    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic        g, r, d;
      logic [31:0] t;
      g = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 39) == 0);
      t = 32'($urandom);
`ifdef FETCH_MISALIGN_CHK_EN
      t = t & 32'hFFFF_FFFC;
`endif
      cycle(g, r, d, t);
    end

    repeat (DEPTH + 3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    do_reset();
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Reset while a response is in flight: it must not reach the buffer.
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    do_reset();
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);

`ifdef FETCH_MISALIGN_CHK_EN
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0102);
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("fault_sticky", 32'(fetch_fault), 32'd1);
    do_reset();
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the instruction buffer entry count (power of two, minimum 2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning the asynchronous, active-high reset.
REQ-005 SHALL have port imem_req  output  1  meaning a fetch request is valid this cycle.
REQ-006 SHALL have port imem_addr  output  32  meaning the word-aligned fetch address.
REQ-007 SHALL have port imem_gnt  input  1  meaning memory accepts the request this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  meaning the response is valid, exactly 1 cycle after an accepted request.
REQ-009 SHALL have port imem_rdata  input  32  meaning the instruction word of the response.
REQ-010 SHALL have port redirect_valid  input  1  meaning branch/jump redirect.
REQ-011 SHALL have port redirect_pc  input  32  meaning the redirect target.
REQ-012 SHALL have port inst_valid  output  1  meaning the buffer head is valid toward the field decoder.
REQ-013 SHALL have port inst_ready  input  1  meaning the decoder accepts the head.
REQ-014 SHALL have port inst_data  output  32  meaning the head instruction word.
REQ-015 SHALL have port inst_pc  output  32  meaning the head instruction address.
REQ-016 SHALL have port fetch_fault  output  1  meaning a sticky misaligned-redirect flag.

Function
REQ-017 SHALL accept a request when imem_req and imem_gnt are both 1; fetch PC += 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0) on each accepted request.
REQ-018 SHALL assert imem_req only when count + inflight < DEPTH, where inflight (0/1) marks an accepted request awaiting its response; imem_req SHALL NOT depend on imem_gnt.
REQ-019 SHALL keep imem_addr stable while imem_req is held and imem_gnt is 0.
REQ-020 SHALL enqueue {imem_rdata, PC of the originating request} at the tail when imem_rvalid is 1 and the response is not discarded.
REQ-021 SHALL present the head combinationally on inst_data/inst_pc; inst_valid = (count != 0).
REQ-022 SHALL dequeue on inst_valid and inst_ready; simultaneous enqueue and dequeue SHALL leave count unchanged, including when full.
REQ-023 SHALL sustain 1 instruction/cycle with inst_ready held high; the first inst_valid SHALL occur 2 cycles after the first accepted request.
REQ-024 SHALL, on redirect_valid: clear the buffer (count=0), load fetch PC with redirect_pc, and mark any in-flight response as discard; the next cycle SHALL issue a request at redirect_pc.
REQ-025 SHALL honour a dequeue handshake in the redirect cycle, then clear; a response arriving in the redirect cycle SHALL be discarded.
REQ-026 SHALL suppress imem_req during the redirect cycle itself.
REQ-027 SHALL wrap head/tail pointers modulo DEPTH; count SHALL be in the range 0..DEPTH.

Reset
REQ-028 SHALL, on reset assertion, immediately force: fetch PC=RESET_PC, count=0, inflight=0, discard=0, pointers=0, fetch_fault=0, imem_req=0, inst_valid=0.
REQ-029 SHALL drop any response returning in the first cycle after reset deassertion if its request preceded reset.
REQ-030 SHALL issue the first request at RESET_PC in the first clock edge after reset deassertion.

Configuration
REQ-031 SHALL, with FETCH_MISALIGN_CHK_EN defined, on a redirect with redirect_pc[1:0] != 0, set fetch_fault=1 (sticky until reset), flush the buffer, and stop issuing requests.
REQ-032 SHALL, without FETCH_MISALIGN_CHK_EN, force redirect_pc[1:0] to 00 and tie fetch_fault to 0.

Verification
REQ-033 SHALL cover: reset, imem_gnt=1, inst_ready=1 -> PCs 0x0,0x4,0x8 out on consecutive cycles, first inst_valid 2 cycles after the first grant.
REQ-034 SHALL cover: inst_ready=0, DEPTH=4 -> exactly 4 entries, imem_req low while full; inst_ready=1 -> order preserved with no loss.
REQ-035 SHALL cover: redirect to 0x100 while a request is in flight -> stale word never output; the next inst_pc=0x100.
REQ-036 SHALL cover: imem_gnt toggled 1/0 pseudo-randomly -> imem_addr stable during wait; inst_pc sequence strictly +4.
REQ-037 SHALL cover: with FETCH_MISALIGN_CHK_EN, redirect to 0x102 -> fetch_fault=1 next cycle, imem_req stays 0, inst_valid=0 until reset.
REQ-038 SHALL cover: reset asserted mid-stream with a full buffer -> all outputs cleared asynchronously; after release, fetch restarts at RESET_PC.
